scroll_display_controller: RTL and testbench
============================================

// Module: scroll_display_controller
// PURPOSE
//  Sequencer for the 4-digit seven-segment name scroller. It holds a programmable message of 4-bit
//  glyph codes and generates the digit-multiplex and scroll timing as clock enables in the clk
//  domain, so no derived clocks are used. Each cycle it drives one glyph code and the active-low
//  anode pattern. The glyph code feeds BCD_display0 directly.
// PARAMETERS
//  REFRESH_DIV  250000     clk cycles per digit-select step (100 MHz -> 400 Hz step, 100 Hz/frame)
//  SCROLL_DIV   100000000  clk cycles per scroll step (1 Hz at 100 MHz)
//  MAX_LEN      16         message memory depth; power of two, >= 4
//  BLANK_CODE   4'hF       glyph code decoded as all-segments-off
// PORTS
//  clk      in   1                 system clock
//  reset    in   1                 asynchronous, active-high reset
//  start    in   1                 1-cycle pulse: begin display of the loaded message
//  stop     in   1                 1-cycle pulse: return to IDLE, blank display
//  hold     in   1                 level: freeze scrolling, keep refreshing
//  wr_en    in   1                 message write strobe
//  wr_addr  in   $clog2(MAX_LEN)   message write index
//  wr_data  in   4                 glyph code to write
//  msg_len  in   $clog2(MAX_LEN)+1 message length, sampled on accepted start
//  digit    out  4                 glyph code for the currently selected digit
//  an       out  4                 anode enables, active-low, one-hot-zero
//  running  out  1                 1 in RUN or HOLD
// BEHAVIOUR
//  - Reset (async): state=IDLE, ptr=0, sel=0, both divider counters=0, an=4'b1111,
//    digit=BLANK_CODE, running=0. Message memory is not reset.
//  - FSM IDLE/RUN/HOLD. start in IDLE with 1<=msg_len<=MAX_LEN: latch len_r, ptr=0, sel=0,
//    counters=0 -> RUN. Any other start is ignored: out-of-range length, or start in RUN/HOLD.
//    RUN & hold -> HOLD; HOLD & !hold -> RUN. stop in any state -> IDLE. stop beats start in the same cycle.
//  - Refresh divider counts 0..REFRESH_DIV-1 in RUN/HOLD and emits ref_tick on wrap.
//    On ref_tick, sel <= sel+1 (mod 4).
//  - Scroll divider counts only in RUN and freezes (keeps its value) in HOLD. It emits scr_tick on wrap.
//    On scr_tick with len_r>=4, ptr <= (ptr==len_r-1) ? 0 : ptr+1. With len_r<4, ptr stays 0.
//  - Position k (0=rightmost, an=1110; 3=leftmost, an=0111) shows offset off=3-k.
//    If off>=len_r: BLANK_CODE.
//    Else: idx=ptr+off; if idx>=len_r then idx-=len_r; show mem[idx].
//    The width of idx is $clog2(MAX_LEN)+1, so the sum cannot overflow.
//  - digit and an are registered and change together one cycle after sel changes, never glitching mid-pattern.
//    In IDLE: an=4'b1111, digit=BLANK_CODE, updated on the cycle after stop.
//  - Writes are accepted in any state with 1-cycle write latency. A write during RUN is visible at the next
//    read of that index. A write and a read of the same index in the same cycle return the old data.
//  - Reset mid-operation blanks the display immediately, with no completion of the current frame.
// STRUCTURE
//  - Package scroll_pkg: state enum (IDLE, RUN, HOLD), AN_OFF=4'b1111, the AN_SEL[0..3] patterns,
//    and the BLANK_CODE default.
//  - Sub-module tick_gen #(DIV): counter with enable and synchronous clear, 1-cycle tick output.
//    Instantiated twice (refresh, scroll).
//  - The message memory is an inferred register array in this module.
// TESTING (bench uses REFRESH_DIV=4, SCROLL_DIV=64, MAX_LEN=16)
//  1. Assert reset mid-run -> same cycle an=1111, digit=F, running=0; after release, state stays IDLE.
//  2. Write {1,2,3,4,5} to idx 0..4, msg_len=5, start -> frame shows an0111:1, 1011:2, 1101:3, 1110:4.
//     After 1 scr_tick the frame is 2,3,4,5; after 2 ticks it is 3,4,5,1 (wrap). After 5 ticks it is back to 1,2,3,4.
//  3. msg_len=2 with mem {7,8} -> leftmost 7, next 8, two right digits F.
//     ptr stays 0 across 10 scr_tick periods.
//  4. start with msg_len=0, then with msg_len=17 -> running stays 0, an=1111.
//  5. Assert hold for 200 cycles in RUN -> glyph-per-anode mapping unchanged, an keeps cycling every 4 clk.
//     The scroll resumes from the frozen count after hold drops.
//  6. start and stop in the same cycle while IDLE -> stays IDLE. stop during RUN -> an=1111 next cycle.

Source files
------------

// File: rtl/scroll_display_controller_pkg.sv
// scroll_pkg: shared state encoding, anode patterns and blank glyph for the name scroller.
package scroll_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam logic [3:0] AN_OFF = 4'b1111;
    // Index k selects position k: 0 is the rightmost digit, 3 the leftmost.
    localparam logic [3:0][3:0] AN_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0] BLANK_DEF = 4'hF;
endpackage

// File: rtl/scroll_display_controller_if.sv
// scroll_display_controller_if: control, message-write and display signals of the scroller.
interface scroll_display_controller_if #(parameter int MAX_LEN = 16);
    localparam int AW = $clog2(MAX_LEN);
    logic          start;
    logic          stop;
    logic          hold;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic [AW:0]   msg_len;
    logic [3:0]    digit;
    logic [3:0]    an;
    logic          running;
    modport master (output start, stop, hold, wr_en, wr_addr, wr_data, msg_len,
                    input digit, an, running);
    modport slave (input start, stop, hold, wr_en, wr_addr, wr_data, msg_len,
                   output digit, an, running);
endinterface

// File: rtl/scroll_display_controller_tick_gen.sv
// tick_gen: modulo-DIV counter with enable and sync clear; tick is high on the wrap cycle.
module tick_gen #(parameter int DIV = 4) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = en && cnt_q == W'(DIV - 1);
        cnt_d = clr ? '0 : tick ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/scroll_display_controller.sv
// scroll_display_controller: multiplexes a scrolling glyph message onto a 4-digit display
// using clock-enable ticks only; digit and anode outputs are registered together.
module scroll_display_controller import scroll_pkg::*; #(
    parameter int         REFRESH_DIV = 250000,
    parameter int         SCROLL_DIV  = 100000000,
    parameter int         MAX_LEN     = 16,
    parameter logic [3:0] BLANK_CODE  = BLANK_DEF
) (
    input logic clk,
    input logic reset,
    scroll_display_controller_if.slave bus
);
    localparam int AW = $clog2(MAX_LEN);
    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    digit_q, digit_d, an_q, an_d;
    logic [3:0]    mem_q [MAX_LEN];
    logic          ref_tick, scr_tick, start_ok, active, blank;
    logic [1:0]    off;
    logic [AW:0]   sum, idx;
    tick_gen #(.DIV(REFRESH_DIV)) u_ref (
        .clk(clk), .reset(reset), .en(active), .clr(!active), .tick(ref_tick));
    // Scroll divider stays enabled-off in HOLD so it resumes from its frozen count.
    tick_gen #(.DIV(SCROLL_DIV)) u_scr (
        .clk(clk), .reset(reset), .en(state_q == RUN), .clr(!active), .tick(scr_tick));
    always_comb begin
        active   = state_q != IDLE;
        start_ok = state_q == IDLE && bus.start && !bus.stop && bus.msg_len != '0 &&
                   bus.msg_len <= (AW+1)'(MAX_LEN);
        state_d  = bus.stop ? IDLE :
                   start_ok ? RUN :
                   (state_q == RUN && bus.hold) ? HOLD :
                   (state_q == HOLD && !bus.hold) ? RUN : state_q;
        len_d    = start_ok ? bus.msg_len : len_q;
        sel_d    = start_ok ? 2'd0 : ref_tick ? sel_q + 2'd1 : sel_q;
        ptr_d    = start_ok ? '0 :
                   (scr_tick && len_q >= (AW+1)'(4)) ?
                   (({1'b0, ptr_q} == len_q - 1'b1) ? '0 : ptr_q + 1'b1) : ptr_q;
        off      = 2'd3 - sel_q;
        sum      = (AW+1)'(ptr_q) + (AW+1)'(off);
        idx      = sum >= len_q ? sum - len_q : sum;
        blank    = !active || bus.stop;
        digit_d  = blank ? BLANK_CODE :
                   ((AW+1)'(off) >= len_q) ? BLANK_CODE : mem_q[idx[AW-1:0]];
        an_d     = blank ? AN_OFF : AN_SEL[sel_q];
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= 2'd0;
            digit_q <= BLANK_CODE;
            an_q    <= AN_OFF;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            digit_q <= digit_d;
            an_q    <= an_d;
        end
    // Reads above see the pre-write contents, so a same-cycle write/read returns old data.
    always_ff @(posedge clk)
        if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
    assign bus.digit   = digit_q;
    assign bus.an      = an_q;
    assign bus.running = active;
endmodule

// File: tb/tb_scroll_display_controller.sv
// tb_scroll_display_controller: table-driven frame checks plus directed reset/hold/stop sequences.
module tb_scroll_display_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    scroll_display_controller_if #(.MAX_LEN(16)) bus();
    scroll_display_controller #(.REFRESH_DIV(4), .SCROLL_DIV(64), .MAX_LEN(16)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [4:0]  len;
        logic [63:0] data;
        int          n;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[12];
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic capture(output logic [15:0] fr, output logic ok);
        logic [3:0] seen;
        int k;
        seen = '0;
        ok = 1'b1;
        fr = '0;
        for (int i = 0; i < 16; i++) begin
            k = bus.an == 4'b1110 ? 0 : bus.an == 4'b1101 ? 1 :
                bus.an == 4'b1011 ? 2 : bus.an == 4'b0111 ? 3 : -1;
            if (k < 0) ok = 1'b0;
            else begin
                fr[k*4 +: 4] = bus.digit;
                seen[k] = 1'b1;
            end
            step(1);
        end
        ok = ok && seen == 4'hF;
    endtask
    task automatic check_frame(input string name, input logic [15:0] exp);
        logic [15:0] fr;
        logic ok;
        capture(fr, ok);
        check(name, {15'b0, ok, fr}, {15'b0, 1'b1, exp});
    endtask
    task automatic load_start(input logic [4:0] len, input logic [63:0] data);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        for (int i = 0; i < int'(len) && i < 16; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_addr = 4'(i);
            bus.wr_data = data[i*4 +: 4];
            step(1);
        end
        bus.wr_en = 1'b0;
        bus.msg_len = len;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask
    initial begin
        logic [3:0] prev;
        int trans;
        vecs[0]  = '{5'd5,  64'h54321, 0, 16'h1234};
        vecs[1]  = '{5'd5,  64'h54321, 1, 16'h2345};
        vecs[2]  = '{5'd5,  64'h54321, 2, 16'h3451};
        vecs[3]  = '{5'd5,  64'h54321, 4, 16'h5123};
        vecs[4]  = '{5'd5,  64'h54321, 5, 16'h1234};
        vecs[5]  = '{5'd2,  64'h87, 0, 16'h78FF};
        vecs[6]  = '{5'd2,  64'h87, 10, 16'h78FF};
        vecs[7]  = '{5'd16, 64'hFEDCBA9876543210, 15, 16'hF012};
        vecs[8]  = '{5'd16, 64'hFEDCBA9876543210, 16, 16'h0123};
        vecs[9]  = '{5'd4,  64'hCBA9, 1, 16'hABC9};
        vecs[10] = '{5'd1,  64'h6, 3, 16'h6FFF};
        vecs[11] = '{5'd3,  64'h321, 7, 16'h123F};
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.hold = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.msg_len = '0;
        step(2);
        check("reset_an", 32'(bus.an), 32'hF);
        check("reset_digit", 32'(bus.digit), 32'hF);
        check("reset_running", 32'(bus.running), 32'h0);
        reset = 1'b0;
        step(1);
        for (int v = 0; v < 12; v++) begin
            load_start(vecs[v].len, vecs[v].data);
            step(64 * vecs[v].n + 2);
            check_frame($sformatf("frame_v%0d", v), vecs[v].exp);
            check($sformatf("running_v%0d", v), 32'(bus.running), 32'h1);
        end
        // A write to index 0 during RUN shows up in the leftmost digit of the same frame.
        load_start(5'd5, 64'h54321);
        step(1);
        bus.wr_en = 1'b1;
        bus.wr_addr = 4'd0;
        bus.wr_data = 4'd9;
        step(1);
        bus.wr_en = 1'b0;
        check_frame("write_in_run", 16'h9234);
        // Reset mid-run blanks at once and leaves the controller idle.
        load_start(5'd5, 64'h54321);
        step(30);
        reset = 1'b1;
        #1;
        check("midreset_an", 32'(bus.an), 32'hF);
        check("midreset_digit", 32'(bus.digit), 32'hF);
        check("midreset_running", 32'(bus.running), 32'h0);
        step(1);
        reset = 1'b0;
        step(3);
        check("postreset_running", 32'(bus.running), 32'h0);
        check("postreset_an", 32'(bus.an), 32'hF);
        load_start(5'd0, 64'h0);
        step(3);
        check("len0_running", 32'(bus.running), 32'h0);
        check("len0_an", 32'(bus.an), 32'hF);
        load_start(5'd17, 64'h0);
        step(3);
        check("len17_running", 32'(bus.running), 32'h0);
        check("len17_an", 32'(bus.an), 32'hF);
        bus.start = 1'b1;
        bus.stop = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        step(2);
        check("startstop_running", 32'(bus.running), 32'h0);
        check("startstop_an", 32'(bus.an), 32'hF);
        load_start(5'd5, 64'h54321);
        step(20);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        check("stop_an", 32'(bus.an), 32'hF);
        check("stop_digit", 32'(bus.digit), 32'hF);
        check("stop_running", 32'(bus.running), 32'h0);
        // Hold from p=10 to p=210; the scroll count freezes at 11 and the tick lands at p=264.
        load_start(5'd5, 64'h54321);
        step(10);
        bus.hold = 1'b1;
        step(10);
        check_frame("hold_frame_early", 16'h1234);
        check("hold_running", 32'(bus.running), 32'h1);
        prev = bus.an;
        trans = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (bus.an != prev) trans++;
            prev = bus.an;
        end
        check("hold_an_cycling", 32'(trans), 32'd10);
        step(114);
        check_frame("hold_frame_late", 16'h1234);
        step(4);
        bus.hold = 1'b0;
        step(35);
        check_frame("resume_before_tick", 16'h1234);
        step(5);
        check_frame("resume_after_tick", 16'h2345);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
